vga_digit_overlay: RTL and testbench

Parametrised BCD digit overlay for the VGA path: composites up to `NUM_FIELDS` two-digit fields (clock, date, timer) onto the interface-ROM background wherever that background carries the key colour. Field values, positions and the cursor select are written over the controller's register bus into a shadow bank. The shadow bank is committed once per frame, which keeps the display tear-free. Sits between the interface ROM/pixel counter and the RGB output stage. It drives the numeral-ROM address and consumes that ROM's data.

---
 rtl/vga_digit_overlay_if.sv | 9 +
 rtl/vga_digit_overlay.sv | 185 ++++++++++++++++++
 tb/tb_vga_digit_overlay.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_digit_overlay_if.sv
// Controller register-bus write port feeding the digit overlay shadow bank.
interface vga_digit_overlay_if;
  logic       Write;
  logic [7:0] MemAddrIN;
  logic [7:0] MemDataIN;

  modport master (output Write, output MemAddrIN, output MemDataIN);
  modport slave  (input  Write, input  MemAddrIN, input  MemDataIN);
endinterface

// File: rtl/vga_digit_overlay.sv
// Composites two-digit BCD fields onto key-coloured background pixels; registers are
// double-buffered and committed once per frame, three-stage pixel pipeline.
module vga_digit_overlay #(
  parameter int unsigned NUM_FIELDS   = 9,
  parameter int unsigned DIGIT_W      = 40,
  parameter int unsigned DIGIT_H      = 60,
  parameter int unsigned NA_W         = 15,
  parameter int unsigned VAL_BASE     = 40,
  parameter int unsigned XPOS_BASE    = 64,
  parameter int unsigned YPOS_BASE    = 96,
  parameter int unsigned CURSOR_ADDR  = 49,
  parameter int unsigned CURSOR_ROWS  = 5,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [5:0]  KEY_COLOR    = 6'b000001,
  parameter logic [5:0]  CURSOR_COLOR = 6'b000010
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [9:0]          PosX,
  input  logic [9:0]          PosY,
  input  logic [5:0]          BgRGB,
  input  logic                VSync,
  vga_digit_overlay_if.slave  bus,
  output logic [NA_W-1:0]     NumAddr,
  input  logic [5:0]          NumRGB,
  output logic [5:0]          OutRGB
);

  localparam int unsigned FW = $clog2(BLINK_FRAMES) + 1;

  logic [7:0]    r_sh_val [NUM_FIELDS];
  logic [7:0]    r_sh_x   [NUM_FIELDS];
  logic [7:0]    r_sh_y   [NUM_FIELDS];
  logic [7:0]    r_act_val[NUM_FIELDS];
  logic [7:0]    r_act_x  [NUM_FIELDS];
  logic [7:0]    r_act_y  [NUM_FIELDS];
  logic [7:0]    r_sh_cursor, r_act_cursor;
  logic          r_vsync_q, r_commit;
  logic [FW-1:0] r_frame;
  logic          r_phase;

  // Register bank, frame commit and blink counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NUM_FIELDS); i++) begin
        r_sh_val[i]  <= '0;
        r_sh_x[i]    <= '0;
        r_sh_y[i]    <= '0;
        r_act_val[i] <= '0;
        r_act_x[i]   <= '0;
        r_act_y[i]   <= '0;
      end
      r_sh_cursor  <= 8'hFF;
      r_act_cursor <= 8'hFF;
      r_vsync_q    <= 1'b1;
      r_commit     <= 1'b0;
      r_frame      <= '0;
      r_phase      <= 1'b1;
    end else begin
      r_vsync_q <= VSync;
      r_commit  <= r_vsync_q & ~VSync;
      // Commit copies pre-edge shadow, so a same-cycle write waits a frame
      if (r_commit) begin
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
          r_act_val[i] <= r_sh_val[i];
          r_act_x[i]   <= r_sh_x[i];
          r_act_y[i]   <= r_sh_y[i];
        end
        r_act_cursor <= r_sh_cursor;
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
      if (bus.Write) begin
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
          if (bus.MemAddrIN == 8'(VAL_BASE + i))  r_sh_val[i] <= bus.MemDataIN;
          if (bus.MemAddrIN == 8'(XPOS_BASE + i)) r_sh_x[i]   <= bus.MemDataIN;
          if (bus.MemAddrIN == 8'(YPOS_BASE + i)) r_sh_y[i]   <= bus.MemDataIN;
        end
        if (bus.MemAddrIN == 8'(CURSOR_ADDR)) r_sh_cursor <= bus.MemDataIN;
      end
    end
  end

  logic [9:0]            w_fx[NUM_FIELDS];
  logic [9:0]            w_fy[NUM_FIELDS];
  logic [NUM_FIELDS-1:0] w_fhit;

  always_comb begin
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      w_fx[i]   = {r_act_x[i], 2'b00};
      w_fy[i]   = {1'b0, r_act_y[i], 1'b0};
      w_fhit[i] = (r_act_x[i] != 8'd0)
               && (PosX >= w_fx[i]) && ({1'b0, PosX} < {1'b0, w_fx[i]} + 11'(2 * DIGIT_W))
               && (PosY >= w_fy[i]) && ({1'b0, PosY} < {1'b0, w_fy[i]} + 11'(DIGIT_H));
    end
  end

  logic       w_hit, w_units;
  logic [7:0] w_idx, w_val;
  logic [9:0] w_bx, w_by, w_dx, w_dy;
  logic [3:0] w_digit;

  // Descending scan so the lowest hitting index is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_bx  = '0;
    w_by  = '0;
    w_val = '0;
    for (int i = int'(NUM_FIELDS) - 1; i >= 0; i--) begin
      if (w_fhit[i]) begin
        w_hit = 1'b1;
        w_idx = 8'(i);
        w_bx  = w_fx[i];
        w_by  = w_fy[i];
        w_val = r_act_val[i];
      end
    end
    w_hit   = w_hit && (BgRGB == KEY_COLOR);
    w_units = (PosX - w_bx) >= 10'(DIGIT_W);
    w_dx    = PosX - w_bx - (w_units ? 10'(DIGIT_W) : 10'd0);
    w_dy    = PosY - w_by;
    w_digit = w_units ? w_val[3:0] : w_val[7:4];
  end

  logic       r1_hit;
  logic [7:0] r1_idx;
  logic [3:0] r1_digit;
  logic [9:0] r1_dx, r1_dy;
  logic [5:0] r1_bg;

  logic       w_blank, w_uline;
  logic       r2_hit, r2_blank, r2_uline;
  logic [5:0] r2_bg;
  logic [NA_W-1:0] r_num_addr;
  logic [5:0] r_out;

  always_comb begin
    w_blank = r1_digit >= 4'd10;
    w_uline = (r_act_cursor == r1_idx) && r_phase
           && (r1_dy >= 10'(DIGIT_H - CURSOR_ROWS));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r1_hit     <= 1'b0;
      r1_idx     <= '0;
      r1_digit   <= '0;
      r1_dx      <= '0;
      r1_dy      <= '0;
      r1_bg      <= '0;
      r2_hit     <= 1'b0;
      r2_blank   <= 1'b0;
      r2_uline   <= 1'b0;
      r2_bg      <= '0;
      r_num_addr <= '0;
      r_out      <= '0;
    end else begin
      r1_hit     <= w_hit;
      r1_idx     <= w_idx;
      r1_digit   <= w_digit;
      r1_dx      <= w_dx;
      r1_dy      <= w_dy;
      r1_bg      <= BgRGB;
      r2_hit     <= r1_hit;
      r2_blank   <= w_blank;
      r2_uline   <= w_uline;
      r2_bg      <= r1_bg;
      r_num_addr <= NA_W'(32'(r1_dx) + DIGIT_W * (32'(r1_dy) + DIGIT_H * 32'(r1_digit)));
      // NumRGB here is the ROM's answer to the address registered last cycle
      if (!r2_hit)        r_out <= r2_bg;
      else if (r2_blank)  r_out <= 6'b000000;
      else if (r2_uline)  r_out <= CURSOR_COLOR;
      else                r_out <= NumRGB;
    end
  end

  assign NumAddr = r_num_addr;
  assign OutRGB  = r_out;

endmodule

// File: tb/tb_vga_digit_overlay.sv
// Randomized and directed checks of vga_digit_overlay against a frame-level reference model.
module tb_vga_digit_overlay;
  localparam int NF = 9, DW = 40, DH = 60, NAW = 15;
  localparam int VB = 40, XB = 64, YB = 96, CA = 49, CR = 5, BF = 30;
  localparam logic [5:0] KEY = 6'b000001, CUR = 6'b000010, IDLE_BG = 6'h3C;

  logic           clk = 1'b0;
  logic           rst;
  logic [9:0]     pos_x, pos_y;
  logic [5:0]     bg_rgb, num_rgb, out_rgb;
  logic           vsync;
  logic [NAW-1:0] num_addr;

  vga_digit_overlay_if bus_if ();

  vga_digit_overlay #(
    .NUM_FIELDS(NF), .DIGIT_W(DW), .DIGIT_H(DH), .NA_W(NAW), .VAL_BASE(VB),
    .XPOS_BASE(XB), .YPOS_BASE(YB), .CURSOR_ADDR(CA), .CURSOR_ROWS(CR),
    .BLINK_FRAMES(BF), .KEY_COLOR(KEY), .CURSOR_COLOR(CUR)
  ) dut (
    .CLK(clk), .RESET(rst), .PosX(pos_x), .PosY(pos_y), .BgRGB(bg_rgb), .VSync(vsync),
    .bus(bus_if), .NumAddr(num_addr), .NumRGB(num_rgb), .OutRGB(out_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_data(int unsigned a);
    return 6'((a * 37) ^ (a >> 5));
  endfunction

  assign num_rgb = rom_data(32'(num_addr));

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: shadow/active banks in plain integers
  int m_sh_val[NF], m_sh_x[NF], m_sh_y[NF];
  int m_ac_val[NF], m_ac_x[NF], m_ac_y[NF];
  int m_sh_cur, m_ac_cur, m_frames;
  bit m_phase, m_prev_vs, m_pend;

  typedef struct { bit hit; int unsigned addr; logic [5:0] out; } exp_t;
  exp_t hist[3];

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_sh_val[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0;
      m_ac_val[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0;
    end
    m_sh_cur = 255; m_ac_cur = 255; m_frames = 0;
    m_phase = 1; m_prev_vs = 1; m_pend = 0;
    for (int k = 0; k < 3; k++) begin
      hist[k].hit = 0; hist[k].addr = 0; hist[k].out = 6'd0;
    end
  endtask

  function automatic exp_t render(int px, int py, logic [5:0] bg);
    exp_t e;
    int fx, fy, units, digit, dx, dy;
    e.hit = 0; e.addr = 0; e.out = bg;
    if (bg != KEY) return e;
    for (int i = 0; i < NF; i++) begin
      if (m_ac_x[i] == 0) continue;
      fx = m_ac_x[i] * 4;
      fy = m_ac_y[i] * 2;
      if (px >= fx && px < fx + 2 * DW && py >= fy && py < fy + DH) begin
        units = (px >= fx + DW) ? 1 : 0;
        digit = units ? m_ac_val[i] % 16 : m_ac_val[i] / 16;
        dx = px - fx - (units ? DW : 0);
        dy = py - fy;
        e.hit = 1;
        e.addr = (dx + DW * (dy + DH * digit)) % (1 << NAW);
        if (digit >= 10) e.out = 6'd0;
        else if (m_ac_cur == i && m_phase && dy >= DH - CR) e.out = CUR;
        else e.out = rom_data(e.addr);
        return e;
      end
    end
    return e;
  endfunction

  task automatic cycle();
    int a, d;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = render(int'(pos_x), int'(pos_y), bg_rgb);
      if (m_pend) begin
        for (int i = 0; i < NF; i++) begin
          m_ac_val[i] = m_sh_val[i]; m_ac_x[i] = m_sh_x[i]; m_ac_y[i] = m_sh_y[i];
        end
        m_ac_cur = m_sh_cur;
        if (m_frames == BF - 1) begin m_frames = 0; m_phase = !m_phase; end
        else m_frames++;
      end
      m_pend = m_prev_vs && !vsync;
      m_prev_vs = vsync;
      if (bus_if.Write) begin
        a = int'(bus_if.MemAddrIN);
        d = int'(bus_if.MemDataIN);
        if (a >= VB && a < VB + NF) m_sh_val[a - VB] = d;
        else if (a >= XB && a < XB + NF) m_sh_x[a - XB] = d;
        else if (a >= YB && a < YB + NF) m_sh_y[a - YB] = d;
        else if (a == CA) m_sh_cur = d;
      end
    end
    #1;
    check_eq("stream_out", 32'(out_rgb), 32'(hist[2].out));
    if (hist[1].hit) check_eq("stream_addr", 32'(num_addr), hist[1].addr);
  endtask

  task automatic set_idle();
    pos_x = 10'd0; pos_y = 10'd0; bg_rgb = IDLE_BG;
  endtask

  task automatic bus_write(int a, int d);
    bus_if.Write = 1'b1; bus_if.MemAddrIN = 8'(a); bus_if.MemDataIN = 8'(d);
    cycle();
    bus_if.Write = 1'b0;
  endtask

  // Optional write lands on the commit edge itself
  task automatic vsync_pulse(bit wr, int a, int d);
    set_idle();
    vsync = 1'b0;
    cycle();
    if (wr) begin
      bus_if.Write = 1'b1; bus_if.MemAddrIN = 8'(a); bus_if.MemDataIN = 8'(d);
    end
    cycle();
    bus_if.Write = 1'b0;
    vsync = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic probe(string tag, int px, int py, logic [5:0] bg, int exp_addr,
                       logic [5:0] exp_out);
    pos_x = 10'(px); pos_y = 10'(py); bg_rgb = bg;
    cycle();
    set_idle();
    cycle();
    if (exp_addr >= 0) check_eq({tag, "_addr"}, 32'(num_addr), 32'(exp_addr));
    cycle();
    check_eq({tag, "_out"}, 32'(out_rgb), 32'(exp_out));
  endtask

  initial begin
    rst = 1'b0;
    vsync = 1'b1;
    bus_if.Write = 1'b0; bus_if.MemAddrIN = 8'd0; bus_if.MemDataIN = 8'd0;
    set_idle();
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_out", 32'(out_rgb), 32'd0);
    check_eq("rst_addr", 32'(num_addr), 32'd0);
    repeat (3) cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // Basic render: X=132, Y=130, value 37
    bus_write(VB, 8'h37);
    bus_write(XB, 33);
    bus_write(YB, 65);
    probe("pre_commit", 172, 131, KEY, -1, KEY);
    vsync_pulse(0, 0, 0);
    probe("basic", 172, 131, KEY, 16840, rom_data(16840));

    // Frame coherence
    bus_write(VB, 8'h12);
    probe("coh_hold", 172, 131, KEY, 16840, rom_data(16840));
    vsync_pulse(0, 0, 0);
    probe("coh_new", 172, 131, KEY, 4840, rom_data(4840));
    vsync_pulse(1, VB, 8'h45);
    probe("coh_same", 172, 131, KEY, 4840, rom_data(4840));
    vsync_pulse(0, 0, 0);
    probe("coh_next", 172, 131, KEY, 12040, rom_data(12040));

    probe("no_key", 172, 131, 6'h15, -1, 6'h15);

    // Blank tens digit, then overlapping field 1
    bus_write(VB, 8'hA5);
    vsync_pulse(0, 0, 0);
    probe("blank_tens", 140, 131, KEY, -1, 6'd0);
    probe("blank_units", 172, 131, KEY, 12040, rom_data(12040));
    bus_write(VB + 1, 8'h99);
    bus_write(XB + 1, 33);
    bus_write(YB + 1, 65);
    vsync_pulse(0, 0, 0);
    probe("priority", 172, 131, KEY, 12040, rom_data(12040));

    // Asynchronous reset mid-line
    pos_x = 10'd172; pos_y = 10'd131; bg_rgb = KEY;
    cycle();
    rst = 1'b1;
    #1;
    check_eq("midrst_out", 32'(out_rgb), 32'd0);
    check_eq("midrst_addr", 32'(num_addr), 32'd0);
    model_reset();
    set_idle();
    repeat (2) cycle();
    rst = 1'b0;
    probe("rst_release", 172, 131, KEY, -1, KEY);

    // Cursor underline and blink
    bus_write(VB, 8'h12);
    bus_write(XB, 33);
    bus_write(YB, 65);
    bus_write(CA, 0);
    vsync_pulse(0, 0, 0);
    probe("cursor_on", 140, 186, KEY, 4648, CUR);
    probe("cursor_above", 140, 184, KEY, 4568, rom_data(4568));
    repeat (29) vsync_pulse(0, 0, 0);
    probe("cursor_off", 140, 186, KEY, 4648, rom_data(4648));
    repeat (30) vsync_pulse(0, 0, 0);
    probe("cursor_back", 140, 186, KEY, 4648, CUR);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < 200; c++) begin
        int i, px, py, sel, fld;
        i  = int'($urandom_range(0, NF - 1));
        px = m_ac_x[i] * 4 + int'($urandom_range(0, 89)) - 5;
        py = m_ac_y[i] * 2 + int'($urandom_range(0, 69)) - 5;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        pos_x = 10'(px);
        pos_y = 10'(py);
        bg_rgb = ($urandom_range(0, 4) != 0) ? KEY : 6'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          sel = int'($urandom_range(0, 9));
          fld = int'($urandom_range(0, NF - 1));
          bus_if.Write = 1'b1;
          bus_if.MemDataIN = 8'($urandom);
          if (sel < 3) bus_if.MemAddrIN = 8'(VB + fld);
          else if (sel < 6) begin
            bus_if.MemAddrIN = 8'(XB + fld);
            bus_if.MemDataIN = 8'($urandom_range(0, 200));
          end else if (sel < 8) begin
            bus_if.MemAddrIN = 8'(YB + fld);
            bus_if.MemDataIN = 8'($urandom_range(0, 200));
          end else if (sel == 8) begin
            bus_if.MemAddrIN = 8'(CA);
            bus_if.MemDataIN = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 10));
          end else bus_if.MemAddrIN = 8'($urandom);
        end else begin
          bus_if.Write = 1'b0;
        end
        cycle();
      end
      bus_if.Write = 1'b0;
      vsync_pulse(0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
